// File: rtl/pe_ctrl_pkg.sv
// Shared types and helpers for the PE0 stage controller: butterfly mode encoding,
// PE select encoding and per-mode pipeline latency.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    K_2_NTT  = 3'd0,
    K_4_NTT  = 3'd1,
    K_2_INTT = 3'd2,
    K_4_INTT = 3'd3,
    D_2_NTT  = 3'd4,
    D_2_INTT = 3'd5
  } pe_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } pe_state_e;

  // Packed as {KD_mode, sel_1, sel_0}.
  typedef logic [2:0] pe_sel_t;

  function automatic logic mode_legal(logic [2:0] m);
    return m <= 3'd5;
  endfunction

  function automatic pe_sel_t sel_of_mode(pe_mode_e m);
    case (m)
      K_2_NTT:  return 3'b000;
      K_4_NTT:  return 3'b001;
      K_2_INTT: return 3'b010;
      K_4_INTT: return 3'b011;
      D_2_NTT:  return 3'b100;
      D_2_INTT: return 3'b110;
      default:  return 3'b000;
    endcase
  endfunction

  // The add-first (inverse, non-KD) path is the longer one.
  function automatic int unsigned lat_of_mode(pe_mode_e m, int unsigned lat_fwd,
                                              int unsigned lat_inv);
    pe_sel_t s;
    s = sel_of_mode(m);
    return (!s[2] && s[1]) ? lat_inv : lat_fwd;
  endfunction

endpackage

// File: rtl/pe0_stage_ctrl_if.sv
// Handshake/bus bundle between the transform sequencer (master) and the PE0 stage
// controller (slave), including the PE select and RAM/ROM address outputs.
interface pe0_stage_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned TW_W   = 8
);

  logic              start;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] n_bf;
  logic [ADDR_W-1:0] rd_base;
  logic [ADDR_W-1:0] wr_base;
  logic [TW_W-1:0]   tw_base;
  logic              hold;

  logic              sel_0;
  logic              sel_1;
  logic              KD_mode;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [TW_W-1:0]   tw_addr;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, mode, n_bf, rd_base, wr_base, tw_base, hold,
    input  sel_0, sel_1, KD_mode, rd_valid, rd_addr, tw_addr,
           wr_valid, wr_addr, busy, done, err
  );

  modport slave (
    input  start, mode, n_bf, rd_base, wr_base, tw_base, hold,
    output sel_0, sel_1, KD_mode, rd_valid, rd_addr, tw_addr,
           wr_valid, wr_addr, busy, done, err
  );

endinterface

// File: rtl/pe_lat_pipe.sv
// Delay line that mirrors the PE0 pipeline: carries {valid, issue ordinal} so the
// write-back strobe and address emerge exactly when PE0_out is valid.
module pe_lat_pipe #(
  parameter  int unsigned DEPTH = 7,
  parameter  int unsigned ORD_W = 8,
  localparam int unsigned LAT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [ORD_W-1:0] in_ord_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic             out_valid_o,
  output logic [ORD_W-1:0] out_ord_o,
  output logic             empty_o
);

  logic [DEPTH-1:0] valid_q;
  logic [ORD_W-1:0] ord_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: only the valid bits are reset; the ordinal payload is never looked at unless
  // its valid bit is set, so leaving it unreset keeps this a plain shift register.
  always_ff @(posedge clk) begin
    ord_q[0] <= in_ord_i;
    for (int i = 1; i < DEPTH; i++) ord_q[i] <= ord_q[i-1];
  end

  // Stage lat-1 is the output tap; "empty" ignores that stage so DRAIN can leave
  // on the same cycle the final write is emitted.
  always_comb begin
    out_valid_o = 1'b0;
    out_ord_o   = '0;
    empty_o     = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (LAT_W'(i + 1) == lat_i) begin
        out_valid_o = valid_q[i];
        out_ord_o   = ord_q[i];
      end else if (LAT_W'(i + 1) < lat_i && valid_q[i]) begin
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pe0_stage_ctrl.sv
// Sequences one butterfly pass through PE0: latches the pass descriptor, drives the
// PE selects, issues coefficient/twiddle reads and aligns write-back with PE0_out.
module pe0_stage_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TW_W    = 8,
  parameter int unsigned LAT_FWD = 5,
  parameter int unsigned LAT_INV = 7
) (
  input logic             clk,
  input logic             rst,
  pe0_stage_ctrl_if.slave bus
);

  localparam int unsigned       LAT_W = $clog2(LAT_INV + 1);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] n_bf;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic [TW_W-1:0]   tw_base;
  } desc_t;

  pe_state_e         state_q, state_d;
  desc_t             desc_q, desc_d;
  logic [ADDR_W-1:0] j_q, j_d;
  pe_sel_t           sel_q, sel_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              err_q, err_d;
  logic              issue;
  logic              pipe_valid;
  logic              pipe_empty;
  logic [ADDR_W-1:0] pipe_ord;

  // NOTE: every output of this block gets a default first, so no path leaves a value
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    j_d     = j_q;
    sel_d   = sel_q;
    lat_d   = lat_q;
    err_d   = 1'b0;
    issue   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (mode_legal(bus.mode)) begin
            desc_d  = '{n_bf: bus.n_bf, rd_base: bus.rd_base,
                        wr_base: bus.wr_base, tw_base: bus.tw_base};
            sel_d   = sel_of_mode(pe_mode_e'(bus.mode));
            lat_d   = LAT_W'(lat_of_mode(pe_mode_e'(bus.mode), LAT_FWD, LAT_INV));
            j_d     = '0;
            state_d = (bus.n_bf == '0) ? ST_DRAIN : ST_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // A held cycle is a bubble: nothing issued, j unchanged, bubble flows down the pipe.
        if (!bus.hold) begin
          issue = 1'b1;
          j_d   = j_q + ONE;
          if (j_q == desc_q.n_bf - ONE) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      desc_q  <= '0;
      j_q     <= '0;
      sel_q   <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      j_q     <= j_d;
      sel_q   <= sel_d;
      lat_q   <= lat_d;
      err_q   <= err_d;
    end
  end

  pe_lat_pipe #(
    .DEPTH (LAT_INV),
    .ORD_W (ADDR_W)
  ) u_lat_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (issue),
    .in_ord_i    (j_q),
    .lat_i       (lat_q),
    .out_valid_o (pipe_valid),
    .out_ord_o   (pipe_ord),
    .empty_o     (pipe_empty)
  );

  assign {bus.KD_mode, bus.sel_1, bus.sel_0} = sel_q;

  // Addresses are forced to zero whenever their strobe is low.
  assign bus.rd_valid = issue;
  assign bus.rd_addr  = issue ? desc_q.rd_base + j_q : '0;
  assign bus.tw_addr  = issue ? desc_q.tw_base + TW_W'(j_q) : '0;

  assign bus.wr_valid = pipe_valid;
  assign bus.wr_addr  = pipe_valid ? desc_q.wr_base + pipe_ord : '0;

  assign bus.busy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.err  = err_q;

endmodule
